// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker for an ASCII character stream, with a sticky error on underflow/overflow.
// Optional synchronous clear port is enabled by defining BLOCK_NEST_CHECKER_CLR_EN.
module block_nest_checker #(
  parameter int DEPTH_W   = 8,
  parameter int MAX_DEPTH = 255
) (
  input  logic               clk,
  input  logic               reset_n,
`ifdef BLOCK_NEST_CHECKER_CLR_EN
  input  logic               clr,
`endif
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               error,
  output logic [3:0]         state_dbg
);

  // Handshake: a character is consumed on a rising clk edge only when in_valid=1; there is no backpressure.

  typedef enum logic [3:0] {
    S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
  } state_e;

  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE_D = DEPTH_W'(1);

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] committed_q, committed_d;
  logic               error_q, error_d;
  logic [7:0]         ch;
  logic               clr_w;
  logic               underflow, overflow;

`ifdef BLOCK_NEST_CHECKER_CLR_EN
  assign clr_w = clr;
`else
  assign clr_w = 1'b0;
`endif

  assign ch = (in >= 8'h41 && in <= 8'h5A) ? (in | 8'h20) : in;

  assign underflow = (state_q == S_END)   && (committed_q == '0);
  assign overflow  = (state_q == S_BEGIN) && (committed_q == MAX_D);

  always_comb begin
    state_d     = state_q;
    committed_d = committed_q;
    error_d     = error_q;
    if (clr_w) begin
      state_d     = S_IDLE;
      committed_d = '0;
      error_d     = 1'b0;
    end else if (in_valid) begin
      if (ch == 8'h20) begin
        state_d = S_IDLE;
        // A pending underflow/overflow turns sticky here; committed is left unchanged.
        if (state_q == S_BEGIN) begin
          if (overflow) error_d = 1'b1;
          else          committed_d = committed_q + ONE_D;
        end else if (state_q == S_END) begin
          if (underflow) error_d = 1'b1;
          else           committed_d = committed_q - ONE_D;
        end
      end else begin
        state_d = S_OTHER;
        unique case (state_q)
          S_IDLE: if (ch == 8'h62) state_d = S_B;
                  else if (ch == 8'h65) state_d = S_E;
          S_B:    if (ch == 8'h65) state_d = S_BE;
          S_BE:   if (ch == 8'h67) state_d = S_BEG;
          S_BEG:  if (ch == 8'h69) state_d = S_BEGI;
          S_BEGI: if (ch == 8'h6E) state_d = S_BEGIN;
          S_E:    if (ch == 8'h6E) state_d = S_EN;
          S_EN:   if (ch == 8'h64) state_d = S_END;
          default: state_d = S_OTHER;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      committed_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      committed_q <= committed_d;
      error_q     <= error_d;
    end
  end

  // Effective depth saturates: a pending underflow shows 0, a pending overflow shows MAX_DEPTH.
  always_comb begin
    depth = committed_q;
    if (state_q == S_BEGIN && !overflow)  depth = committed_q + ONE_D;
    else if (state_q == S_END && !underflow) depth = committed_q - ONE_D;
  end

  assign result    = !error_q && !underflow && !overflow && (depth == '0);
  assign error     = error_q;
  assign state_dbg = state_q;

endmodule
